// File: rtl/write_ddr_fifo_core.sv
// Single-clock 32->256 bit packing FIFO for the DDR write path.
// Eight consecutive writes fill one row, which is read out as a single wide word.
module write_ddr_fifo_core #(
  parameter int WR_DEPTH_WIDTH   = 11,
  parameter int WR_DATA_WIDTH    = 32,
  parameter int RD_DEPTH_WIDTH   = 8,
  parameter int RD_DATA_WIDTH    = 256,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      almost_full,
  input  logic                      rd_en,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  output logic                      rd_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  output logic                      almost_empty
);

  localparam int LANE_BITS = WR_DEPTH_WIDTH - RD_DEPTH_WIDTH;
  localparam int LANES     = 1 << LANE_BITS;
  localparam int ROWS      = 1 << RD_DEPTH_WIDTH;
  localparam int WP_W      = WR_DEPTH_WIDTH + 1;
  localparam int RP_W      = RD_DEPTH_WIDTH + 1;

  localparam logic [WP_W-1:0] WP_ONE = WP_W'(1);
  localparam logic [RP_W-1:0] RP_ONE = RP_W'(1);
  localparam logic [WP_W-1:0] AF_LVL = WP_W'(ALMOST_FULL_NUM);
  localparam logic [RP_W-1:0] AE_LVL = RP_W'(ALMOST_EMPTY_NUM);

  logic [WR_DATA_WIDTH-1:0] mem_q [ROWS][LANES];

  logic [WP_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [RP_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [WP_W-1:0]          wr_lvl_d;
  logic [RP_W-1:0]          rd_lvl_d;
  logic [WP_W-1:0]          wr_lvl_q;
  logic [RP_W-1:0]          rd_lvl_q;
  logic                     wr_full_q, rd_empty_q, almost_full_q, almost_empty_q;
  logic [RD_DATA_WIDTH-1:0] rd_data_q;
  logic                     wr_fire, rd_fire;

  // Acceptance uses the flags from before the edge, so a same-edge write
  // never unblocks a read from empty and vice versa.
  assign wr_fire = wr_en & ~wr_full_q;
  assign rd_fire = rd_en & ~rd_empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + WP_ONE;
    if (rd_fire) rd_ptr_d = rd_ptr_q + RP_ONE;
    // Modulo pointer difference; wrap bits make the full case land on 2048.
    wr_lvl_d = wr_ptr_d - {rd_ptr_d, {LANE_BITS{1'b0}}};
    rd_lvl_d = wr_lvl_d[WP_W-1:LANE_BITS];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wr_lvl_q       <= '0;
      rd_lvl_q       <= '0;
      wr_full_q      <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      rd_data_q      <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_lvl_q       <= wr_lvl_d;
      rd_lvl_q       <= rd_lvl_d;
      wr_full_q      <= wr_lvl_d[WP_W-1];
      rd_empty_q     <= (rd_lvl_d == '0);
      almost_full_q  <= (wr_lvl_d >= AF_LVL);
      almost_empty_q <= (rd_lvl_d <= AE_LVL);
      if (rd_fire) begin
        for (int l = 0; l < LANES; l++) begin
          rd_data_q[l*WR_DATA_WIDTH +: WR_DATA_WIDTH] <= mem_q[rd_ptr_q[RD_DEPTH_WIDTH-1:0]][l];
        end
      end
    end
  end

  // Storage is never reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) begin
      mem_q[wr_ptr_q[WR_DEPTH_WIDTH-1:LANE_BITS]][wr_ptr_q[LANE_BITS-1:0]] <= wr_data;
    end
  end

  assign wr_full        = wr_full_q;
  assign wr_water_level = wr_lvl_q;
  assign almost_full    = almost_full_q;
  assign rd_data        = rd_data_q;
  assign rd_empty       = rd_empty_q;
  assign rd_water_level = rd_lvl_q;
  assign almost_empty   = almost_empty_q;

endmodule

// File: tb/tb_write_ddr_fifo_core.sv
// Scoreboard bench for write_ddr_fifo_core: a word-queue reference model
// predicts packed rows and levels; a negedge monitor compares every cycle.
module tb_write_ddr_fifo_core;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  wr_data;
  logic         wr_en;
  logic         wr_full;
  logic [11:0]  wr_water_level;
  logic         almost_full;
  logic         rd_en;
  logic [255:0] rd_data;
  logic         rd_empty;
  logic [8:0]   rd_water_level;
  logic         almost_empty;

  write_ddr_fifo_core dut (
    .clk            (clk),
    .rst            (rst),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .almost_full    (almost_full),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .almost_empty   (almost_empty)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0]  mq[$];      // words stored, oldest first
  logic [255:0] exp_q[$];   // expected rd_data after each read/reset edge
  logic [255:0] cur_rd = '0;
  bit           mon_en = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: state after the most recent posedge, compared with the model.
  always @(negedge clk) begin
    int n;
    if (mon_en) begin
      n = mq.size();
      if (exp_q.size() > 0) cur_rd = exp_q.pop_front();
      chk("rd_data", rd_data, cur_rd);
      chk("wr_water_level", 256'(wr_water_level), 256'(n));
      chk("rd_water_level", 256'(rd_water_level), 256'(n / 8));
      chk("flags", 256'({wr_full, almost_full, rd_empty, almost_empty}),
          256'({n == 2048, n >= 1020, n < 8, (n / 8) <= 4}));
    end
  end

  // Drives one cycle of stimulus and applies the same edge to the model.
  task automatic step(input bit we, input logic [31:0] wd, input bit re, input bit rs);
    bit fr, fw;
    logic [255:0] row;
    @(negedge clk);
    #1;
    wr_en = we; wr_data = wd; rd_en = re; rst = rs;
    if (rs) begin
      mq.delete();
      exp_q.push_back('0);
    end else begin
      fr = re && (mq.size() >= 8);
      fw = we && (mq.size() < 2048);
      if (fr) begin
        row = '0;
        for (int k = 0; k < 8; k++) row[32*k +: 32] = mq.pop_front();
        exp_q.push_back(row);
      end
      if (fw) mq.push_back(wd);
    end
  endtask

  initial begin
    logic [31:0] cnt;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

    // Reset held for several cycles
    step(0, 0, 0, 1);
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Pack order: first write ends up in bits [31:0]
    for (int i = 0; i < 8; i++) step(1, 32'hFFFF_FFFF - 32'(i), 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Fill to full with one dropped extra write, then over-drain
    cnt = 32'hFFFF_FFFF;
    for (int i = 0; i < 2049; i++) begin step(1, cnt, 0, 0); cnt = cnt - 1; end
    step(0, 0, 0, 0);
    for (int i = 0; i < 257; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Partial row, then 8th write with a blocked read on the same edge
    for (int i = 0; i < 7; i++) step(1, 32'hA000_0000 + 32'(i), 0, 0);
    step(0, 0, 1, 0);
    step(1, 32'hA000_0007, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 32'hB000_0000 + 32'(i), 0, 0);
    step(1, 32'hB000_0010, 1, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

    // Three full fill/drain passes to wrap both pointers
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 2048; i++) step(1, $urandom, 0, 0);
      for (int i = 0; i < 256; i++) step(0, 0, 1, 0);
    end

    // Reset with 100 words stored, then a fresh row starts at lane 0
    for (int i = 0; i < 100; i++) step(1, $urandom, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 32'hC000_0000 + 32'(i), 0, 0);
    step(0, 0, 1, 0);

    // Randomised traffic: a filling phase then a draining phase
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 90, $urandom, $urandom_range(0, 99) < 6,
           $urandom_range(0, 999) == 0);
    for (int i = 0; i < 2500; i++)
      step($urandom_range(0, 99) < 30, $urandom, $urandom_range(0, 99) < 25, 1'b0);

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
